// File: rtl/dcache_pkg.sv
// Shared types and helpers for the two-way set-associative data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int tag_w(input int sets, input int line_bytes);
    return 32 - $clog2(sets) - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: valid/dirty bits with async reset, tag and line storage without reset.
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int SETS    = 32,
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 22,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [INDEX_W-1:0] index,
  input  logic              we,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [LINE_W-1:0] wline,
  input  logic              wdirty,
  input  logic              dirty_clr,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= wdirty;
    end else if (dirty_clr) begin
      dirty_q[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      tag_q[index]  <= wtag;
      line_q[index] <= wline;
    end
  end

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = line_q[index];

endmodule

// File: rtl/dcache_2way.sv
// Two-way set-associative write-back, write-allocate data cache with LRU and saturating counters.
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [8*LINE_BYTES-1:0] mem_data_i,
  input  logic                    mem_ack_i,
  output logic [8*LINE_BYTES-1:0] mem_data_o,
  output logic [31:0]             mem_addr_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  input  logic [31:0]             p1_data_i,
  input  logic [31:0]             p1_addr_i,
  input  logic                    p1_MemRead_i,
  input  logic                    p1_MemWrite_i,
  output logic [31:0]             p1_data_o,
  output logic                    p1_stall_o,
  output logic [31:0]             access_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int INDEX_W  = index_w(SETS);
  localparam int OFFSET_W = offset_w(LINE_BYTES);
  localparam int TAG_W    = tag_w(SETS, LINE_BYTES);
  localparam int LINE_W   = 8 * LINE_BYTES;
  localparam int SEL_W    = OFFSET_W - 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == CNT_SAT) ? c : c + 32'd1;
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] l,
                                                   input logic [SEL_W-1:0]  sel,
                                                   input logic [31:0]       d);
    logic [LINE_W-1:0] r;
    r = l;
    r[32*int'(sel) +: 32] = d;
    return r;
  endfunction

  state_t state_q, state_d;

  logic [TAG_W-1:0]   p1_tag;
  logic [INDEX_W-1:0] p1_index;
  logic [SEL_W-1:0]   word_sel;
  logic               req;
  logic               unused_addr_bits;

  logic [INDEX_W-1:0] arr_index;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic               victim_q;
  logic               victim_d;
  logic               victim_dirty;
  logic [SETS-1:0]    lru_q;

  logic [1:0]         way_valid, way_dirty, way_match, way_we, way_clr;
  logic [TAG_W-1:0]   way_tag  [2];
  logic [LINE_W-1:0]  way_line [2];
  logic [TAG_W-1:0]   wtag;
  logic [LINE_W-1:0]  wline;
  logic               wdirty;

  logic               hit;
  logic               hit_way;
  logic [LINE_W-1:0]  hit_line;
  logic [31:0]        hit_word;

  logic               mem_enable_q, mem_write_q;
  logic [31:0]        mem_addr_q;
  logic [LINE_W-1:0]  mem_data_q;
  logic [31:0]        access_cnt_q, miss_cnt_q;

  assign p1_tag           = p1_addr_i[31:32-TAG_W];
  assign p1_index         = p1_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign word_sel         = p1_addr_i[OFFSET_W-1:2];
  assign unused_addr_bits = ^p1_addr_i[1:0];
  assign req              = p1_MemRead_i | p1_MemWrite_i;

  // After MISS the arrays follow the registered index so a wandering request cannot redirect the refill.
  assign arr_index = (state_q == IDLE || state_q == MISS) ? p1_index : idx_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way_array #(
      .SETS   (SETS),
      .INDEX_W(INDEX_W),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W)
    ) u_way (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .index    (arr_index),
      .we       (way_we[w]),
      .wtag     (wtag),
      .wline    (wline),
      .wdirty   (wdirty),
      .dirty_clr(way_clr[w]),
      .valid    (way_valid[w]),
      .dirty    (way_dirty[w]),
      .tag      (way_tag[w]),
      .line     (way_line[w])
    );
    assign way_match[w] = way_valid[w] && (way_tag[w] == p1_tag);
  end

  // Hits only count in IDLE; every other state keeps the CPU stalled.
  assign hit        = req && (state_q == IDLE) && (|way_match);
  assign hit_way    = way_match[0] ? 1'b0 : 1'b1;
  assign hit_line   = way_line[hit_way];
  assign hit_word   = hit_line[32*int'(word_sel) +: 32];
  assign p1_data_o  = hit ? hit_word : 32'd0;
  assign p1_stall_o = req && !hit;

  assign victim_d     = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[p1_index]);
  assign victim_dirty = way_valid[victim_d] && way_dirty[victim_d];

  always_comb begin
    way_we  = 2'b00;
    way_clr = 2'b00;
    wtag    = p1_tag;
    wline   = merge_word(hit_line, word_sel, p1_data_i);
    wdirty  = 1'b1;
    case (state_q)
      IDLE:      if (hit && p1_MemWrite_i) way_we[hit_way] = 1'b1;
      WRITEBACK: if (mem_ack_i) way_clr[victim_q] = 1'b1;
      READMISS: begin
        if (mem_ack_i) begin
          way_we[victim_q] = 1'b1;
          wtag             = tag_q;
          wline            = mem_data_i;
          wdirty           = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (req && !hit) state_d = MISS;
      MISS:       state_d = victim_dirty ? WRITEBACK : READMISS;
      WRITEBACK:  if (mem_ack_i) state_d = READMISS;
      READMISS:   if (mem_ack_i) state_d = READMISSOK;
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        MISS: begin
          mem_enable_q <= 1'b1;
          mem_write_q  <= victim_dirty;
        end
        WRITEBACK: if (mem_ack_i) mem_write_q <= 1'b0;
        READMISS:  if (mem_ack_i) mem_enable_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == MISS) begin
      victim_q   <= victim_d;
      idx_q      <= p1_index;
      tag_q      <= p1_tag;
      mem_data_q <= way_line[victim_d];
      mem_addr_q <= victim_dirty ? {way_tag[victim_d], p1_index, {OFFSET_W{1'b0}}}
                                 : {p1_tag, p1_index, {OFFSET_W{1'b0}}};
    end else if (state_q == WRITEBACK && mem_ack_i) begin
      mem_addr_q <= {tag_q, idx_q, {OFFSET_W{1'b0}}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lru_q        <= '0;
      access_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (hit) begin
        lru_q[p1_index] <= ~hit_way;
        access_cnt_q    <= sat_inc(access_cnt_q);
      end
      if (state_q == IDLE && req && !hit) miss_cnt_q <= sat_inc(miss_cnt_q);
      if (state_q == READMISS && mem_ack_i) lru_q[idx_q] <= ~victim_q;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign access_cnt_o = access_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule
